// File: rtl/l2_sio_resp_tracker.sv
// L2-bank -> SIO outbound response tracker: per-bank burst FSMs, parity/UE
// flagging, round-robin record arbiter, FWFT record FIFO and saturating stats.
//
// Optional feature macro: L2SIO_PARITY_CHK_EN (defined = per-lane parity check;
// undefined = parity input ignored and par_err always 0).
//
// Ports:
//   iol2clk, iol2_rst           clock, synchronous active-high reset
//   ctag_vld[NBANKS]            per-bank header strobe
//   data[NBANKS*DW]             per-bank data, bank N at [N*DW +: DW]
//   parity[NBANKS*DW/16]        per-bank parity, one bit per 16-bit lane
//   ue_err[NBANKS]              per-bank uncorrectable-error strobe
//   rec_vld/rec_rdy             record stream handshake
//   rec_bank/rec_ctag/rec_flags record fields, flags = {proto_err, par_err, ue}
//   resp_cnt/err_cnt/drop_cnt   saturating statistics
module l2_sio_resp_tracker #(
    parameter int NBANKS     = 8,
    parameter int DW         = 32,
    parameter int BEATS      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                                       iol2clk,
    input  logic                                       iol2_rst,
    input  logic [NBANKS-1:0]                          ctag_vld,
    input  logic [NBANKS*DW-1:0]                       data,
    input  logic [NBANKS*DW/16-1:0]                    parity,
    input  logic [NBANKS-1:0]                          ue_err,
    output logic                                       rec_vld,
    input  logic                                       rec_rdy,
    output logic [(NBANKS > 1 ? $clog2(NBANKS) : 1)-1:0] rec_bank,
    output logic [15:0]                                rec_ctag,
    output logic [2:0]                                 rec_flags,
    output logic [CNT_W-1:0]                           resp_cnt,
    output logic [CNT_W-1:0]                           err_cnt,
    output logic [CNT_W-1:0]                           drop_cnt
);

    localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int LANES = DW / 16;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int RW    = BW + 16 + 3;
    localparam int DCW   = $clog2(NBANKS + 1);

    typedef enum logic {
        S_IDLE,
        S_DATA
    } state_t;

    // ---------------- per-bank burst tracking ----------------
    state_t            state_q [NBANKS];
    state_t            state_d [NBANKS];
    logic [BCW-1:0]    beat_q  [NBANKS];
    logic [BCW-1:0]    beat_d  [NBANKS];
    logic [15:0]       ctag_q  [NBANKS];
    logic [15:0]       ctag_d  [NBANKS];
    logic [NBANKS-1:0] ue_q, ue_d;
    logic [NBANKS-1:0] par_q, par_d;
    logic [NBANKS-1:0] cmpl;
    logic [2:0]        cmpl_flags [NBANKS];
    logic [NBANKS-1:0] lane_err;

`ifdef L2SIO_PARITY_CHK_EN
    always_comb begin
        lane_err = '0;
        for (int b = 0; b < NBANKS; b++) begin
            for (int k = 0; k < LANES; k++) begin
                if (parity[b*LANES+k] != ^data[b*DW+16*k +: 16]) begin
                    lane_err[b] = 1'b1;
                end
            end
        end
    end
`else
    logic unused_parity;
    assign lane_err      = '0;
    assign unused_parity = ^{parity, data};
`endif

    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            state_d[b]    = state_q[b];
            beat_d[b]     = beat_q[b];
            ctag_d[b]     = ctag_q[b];
            ue_d[b]       = ue_q[b];
            par_d[b]      = par_q[b];
            cmpl[b]       = 1'b0;
            cmpl_flags[b] = 3'b000;
            unique case (state_q[b])
                S_IDLE: ;
                S_DATA: begin
                    if (ctag_vld[b]) begin
                        // Header inside a burst: close the old one as aborted;
                        // this beat's errors belong to the new header.
                        cmpl[b]       = 1'b1;
                        cmpl_flags[b] = {1'b1, par_q[b], ue_q[b]};
                    end else if (beat_q[b] == BCW'(BEATS - 1)) begin
                        cmpl[b]       = 1'b1;
                        cmpl_flags[b] = {1'b0, par_q[b] | lane_err[b],
                                         ue_q[b] | ue_err[b]};
                        state_d[b]    = S_IDLE;
                    end else begin
                        beat_d[b] = beat_q[b] + 1'b1;
                        ue_d[b]   = ue_q[b] | ue_err[b];
                        par_d[b]  = par_q[b] | lane_err[b];
                    end
                end
            endcase
            if (ctag_vld[b]) begin
                state_d[b] = S_DATA;
                beat_d[b]  = '0;
                ctag_d[b]  = data[b*DW +: 16];
                ue_d[b]    = ue_err[b];
                par_d[b]   = lane_err[b];
            end
        end
    end

    // ---------------- pending slots and arbiter ----------------
    logic [NBANKS-1:0] pend_vld;
    logic [15:0]       pend_ctag  [NBANKS];
    logic [2:0]        pend_flags [NBANKS];
    logic [BW-1:0]     rr_ptr;
    logic [BW-1:0]     gnt_idx;
    logic [BW-1:0]     cand;
    logic              gnt_any;
    logic [NBANKS-1:0] grant;
    logic [NBANKS-1:0] pend_set;
    logic [NBANKS-1:0] drop;
    logic [DCW-1:0]    drop_n;
    logic              push, pop, full, empty;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NBANKS; i++) begin
            cand = BW'((int'(rr_ptr) + i) % NBANKS);
            if (!gnt_any && pend_vld[cand] && (!full || pop)) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant = gnt_any ? (NBANKS'(1) << gnt_idx) : '0;
    assign push  = gnt_any;

    // A slot draining this cycle can take a new completion at the same edge.
    always_comb begin
        drop_n = '0;
        for (int b = 0; b < NBANKS; b++) begin
            pend_set[b] = cmpl[b] && (!pend_vld[b] || grant[b]);
            drop[b]     = cmpl[b] && pend_vld[b] && !grant[b];
            drop_n      = drop_n + DCW'(drop[b]);
        end
    end

    always_ff @(posedge iol2clk) begin
        if (iol2_rst) begin
            ue_q     <= '0;
            par_q    <= '0;
            pend_vld <= '0;
            for (int b = 0; b < NBANKS; b++) begin
                state_q[b]    <= S_IDLE;
                beat_q[b]     <= '0;
                ctag_q[b]     <= '0;
                pend_ctag[b]  <= '0;
                pend_flags[b] <= '0;
            end
        end else begin
            ue_q  <= ue_d;
            par_q <= par_d;
            for (int b = 0; b < NBANKS; b++) begin
                state_q[b] <= state_d[b];
                beat_q[b]  <= beat_d[b];
                ctag_q[b]  <= ctag_d[b];
                if (pend_set[b]) begin
                    pend_vld[b]   <= 1'b1;
                    pend_ctag[b]  <= ctag_q[b];
                    pend_flags[b] <= cmpl_flags[b];
                end else if (grant[b]) begin
                    pend_vld[b] <= 1'b0;
                end
            end
        end
    end

    // ---------------- record FIFO (first-word-fall-through) ----------------
    logic [RW-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [RW-1:0]    last_q;
    logic [RW-1:0]    head;
    logic [RW-1:0]    push_rec;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] drop_nxt;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = rec_vld && rec_rdy;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign push_rec = {gnt_idx, pend_ctag[gnt_idx], pend_flags[gnt_idx]};
    assign rec_vld  = !empty;
    // When empty the outputs show the last record handed out.
    assign {rec_bank, rec_ctag, rec_flags} = empty ? last_q : head;

    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_n);
    assign drop_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

    always_ff @(posedge iol2clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_rec;
        end
    end

    always_ff @(posedge iol2clk) begin
        if (iol2_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_q   <= '0;
            rr_ptr   <= '0;
            resp_cnt <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                rr_ptr   <= (gnt_idx == BW'(NBANKS - 1)) ? '0 : gnt_idx + 1'b1;
                resp_cnt <= (&resp_cnt) ? resp_cnt : resp_cnt + 1'b1;
                if (|push_rec[2:0]) begin
                    err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= head;
            end
            drop_cnt <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_l2_sio_resp_tracker.sv
// Self-checking bench for l2_sio_resp_tracker (8 banks, 32-bit data, 16 beats).
// Table of single-bank bursts plus directed tie, abort, back-pressure and reset sequences.
module tb_l2_sio_resp_tracker;

    localparam int NB    = 8;
    localparam int DW    = 32;
    localparam int BEATS = 16;
    localparam int FD    = 8;
    localparam int CW    = 16;

`ifdef L2SIO_PARITY_CHK_EN
    localparam logic [2:0] PB = 3'b010;
`else
    localparam logic [2:0] PB = 3'b000;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     ctag_vld, ue_err;
    logic [NB*DW-1:0]  data;
    logic [NB*2-1:0]   parity;
    logic              rec_vld, rec_rdy;
    logic [2:0]        rec_bank;
    logic [15:0]       rec_ctag;
    logic [2:0]        rec_flags;
    logic [CW-1:0]     resp_cnt, err_cnt, drop_cnt;

    logic [NB-1:0]     cv, uv;
    logic [31:0]       dw [NB];
    logic [1:0]        pf [NB];

    int checks = 0;
    int failures = 0;
    int resp_exp = 0;
    int err_exp = 0;

    typedef struct {
        int          bank;
        logic [15:0] ctag;
        int          pbeat;
        int          ubeat;
        logic [2:0]  flags;
    } vec_t;

    vec_t tv [8];

    always #5 clk = ~clk;

    always_comb begin
        ctag_vld = cv;
        ue_err   = uv;
        for (int b = 0; b < NB; b++) begin
            data[b*DW +: DW] = dw[b];
            parity[b*2 +: 2] = {^dw[b][31:16], ^dw[b][15:0]} ^ pf[b];
        end
    end

    l2_sio_resp_tracker #(
        .NBANKS(NB), .DW(DW), .BEATS(BEATS), .FIFO_DEPTH(FD), .CNT_W(CW)
    ) dut (
        .iol2clk  (clk),
        .iol2_rst (rst),
        .ctag_vld (ctag_vld),
        .data     (data),
        .parity   (parity),
        .ue_err   (ue_err),
        .rec_vld  (rec_vld),
        .rec_rdy  (rec_rdy),
        .rec_bank (rec_bank),
        .rec_ctag (rec_ctag),
        .rec_flags(rec_flags),
        .resp_cnt (resp_cnt),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cv = '0;
        uv = '0;
        for (int b = 0; b < NB; b++) begin
            dw[b] = '0;
            pf[b] = '0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rec(input string nm, input int b,
                           input logic [15:0] c, input logic [2:0] f);
        chk({nm, "_vld"}, 32'(rec_vld), 32'd1);
        chk({nm, "_bank"}, 32'(rec_bank), 32'(b));
        chk({nm, "_ctag"}, 32'(rec_ctag), 32'(c));
        chk({nm, "_flags"}, 32'(rec_flags), 32'(f));
    endtask

    task automatic chk_cnts(input string nm);
        chk({nm, "_resp"}, 32'(resp_cnt), 32'(resp_exp));
        chk({nm, "_err"}, 32'(err_cnt), 32'(err_exp));
    endtask

    function automatic logic [31:0] pat(input int b, input int k);
        return {8'(k), 8'(b), 16'h3C5A ^ 16'(k * 257)};
    endfunction

    // All banks in m: header (ctag = base + bank) then BEATS good beats.
    task automatic burst(input logic [NB-1:0] m, input logic [15:0] base);
        for (int k = 0; k <= BEATS; k++) begin
            for (int b = 0; b < NB; b++) begin
                if (m[b]) begin
                    cv[b] = (k == 0);
                    dw[b] = (k == 0) ? {16'hC000 | 16'(b), base + 16'(b)}
                                     : pat(b, k);
                end
            end
            step();
        end
        idle_in();
    endtask

    initial begin
        tv[0] = '{0, 16'h00A5, -1, -1, 3'b000};
        tv[1] = '{2, 16'h1234,  8, 10, PB | 3'b001};
        tv[2] = '{2, 16'h4321, -1, -1, 3'b000};
        tv[3] = '{7, 16'hBEEF, -1,  0, 3'b001};
        tv[4] = '{4, 16'h0F0F,  0, -1, PB};
        tv[5] = '{6, 16'hFFFF, 16, -1, PB};
        tv[6] = '{3, 16'h8001, -1, 16, 3'b001};
        tv[7] = '{1, 16'h5A5A,  1,  1, PB | 3'b001};

        idle_in();
        rec_rdy = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_vld", 32'(rec_vld), 32'd0);
        chk("rst_ctag", 32'(rec_ctag), 32'd0);
        chk("rst_flags", 32'(rec_flags), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk_cnts("rst");

        // Single-bank bursts: exact two-edge latency, then hold when empty.
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k <= BEATS; k++) begin
                cv[tv[v].bank] = (k == 0);
                dw[tv[v].bank] = (k == 0) ? {16'h5000, tv[v].ctag}
                                          : pat(tv[v].bank, k);
                pf[tv[v].bank] = (k == tv[v].pbeat) ? 2'b01 : 2'b00;
                uv[tv[v].bank] = (k == tv[v].ubeat);
                step();
            end
            idle_in();
            chk($sformatf("v%0d_lat", v), 32'(rec_vld), 32'd0);
            step();
            chk_rec($sformatf("v%0d", v), tv[v].bank, tv[v].ctag, tv[v].flags);
            resp_exp++;
            if (tv[v].flags != 3'b000) err_exp++;
            chk_cnts($sformatf("v%0d", v));
            step();
            chk($sformatf("v%0d_empty", v), 32'(rec_vld), 32'd0);
            chk($sformatf("v%0d_hold", v), 32'(rec_ctag), 32'(tv[v].ctag));
        end

        // Tie 3/5 with pointer at 2, then tie 4/7 with pointer at 6.
        burst(8'b0010_1000, 16'h3000);
        chk("tie1_lat", 32'(rec_vld), 32'd0);
        step();
        chk_rec("tie1_a", 3, 16'h3003, 3'b000);
        step();
        chk_rec("tie1_b", 5, 16'h3005, 3'b000);
        step();
        burst(8'b1001_0000, 16'h4000);
        step();
        chk_rec("tie2_a", 7, 16'h4007, 3'b000);
        step();
        chk_rec("tie2_b", 4, 16'h4004, 3'b000);
        resp_exp += 4;
        step();
        chk_cnts("tie");

        // Bank1 restarted by a header at its fifth data beat.
        cv[1] = 1'b1;
        dw[1] = {16'h5000, 16'h0011};
        step();
        for (int k = 1; k <= 4; k++) begin
            cv[1] = 1'b0;
            dw[1] = pat(1, k);
            step();
        end
        cv[1] = 1'b1;
        dw[1] = {16'h5000, 16'h0022};
        step();
        for (int k = 1; k <= BEATS; k++) begin
            cv[1] = 1'b0;
            dw[1] = pat(1, k);
            step();
            if (k == 1) chk_rec("abort", 1, 16'h0011, 3'b100);
        end
        idle_in();
        chk("restart_lat", 32'(rec_vld), 32'd0);
        step();
        chk_rec("restart", 1, 16'h0022, 3'b000);
        resp_exp += 2;
        err_exp += 1;
        chk_cnts("abort");
        step();

        // Back-pressure: round 1 fills the FIFO, round 2 the slots, round 3 drops.
        rec_rdy = 1'b0;
        burst(8'hFF, 16'h5100);
        burst(8'hFF, 16'h5200);
        burst(8'hFF, 16'h5300);
        resp_exp += 8;
        chk("bp_drop", 32'(drop_cnt), 32'd8);
        chk_cnts("bp");
        chk_rec("bp_head", 2, 16'h5102, 3'b000);
        step();
        step();
        step();
        chk_rec("bp_hold", 2, 16'h5102, 3'b000);
        rec_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_rec($sformatf("drain%0d", i), (2 + i) % 8,
                    ((i < 8) ? 16'h5100 : 16'h5200) + 16'((2 + i) % 8),
                    3'b000);
            step();
        end
        resp_exp += 8;
        chk("drain_empty", 32'(rec_vld), 32'd0);
        chk("drain_hold", 32'(rec_ctag), 32'h5201);
        chk("drain_drop", 32'(drop_cnt), 32'd8);
        chk_cnts("drain");

        // Reset in the middle of a bank6 burst.
        begin
            int seen;
            seen = 0;
            for (int k = 0; k <= 10; k++) begin
                cv[6] = (k == 0);
                dw[6] = (k == 0) ? {16'h5000, 16'h6006} : pat(6, k);
                rst = (k == 10);
                step();
            end
            rst = 1'b0;
            idle_in();
            chk("mrst_vld", 32'(rec_vld), 32'd0);
            chk("mrst_bank", 32'(rec_bank), 32'd0);
            chk("mrst_ctag", 32'(rec_ctag), 32'd0);
            chk("mrst_flags", 32'(rec_flags), 32'd0);
            chk("mrst_drop", 32'(drop_cnt), 32'd0);
            resp_exp = 0;
            err_exp = 0;
            chk_cnts("mrst");
            for (int i = 0; i < 20; i++) begin
                step();
                if (rec_vld) seen++;
            end
            chk("mrst_norec", 32'(seen), 32'd0);
        end
        burst(8'h40, 16'h6600);
        chk("post_lat", 32'(rec_vld), 32'd0);
        step();
        chk_rec("post", 6, 16'h6606, 3'b000);
        resp_exp = 1;
        chk_cnts("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
